// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock / reset sequencer.
// Holds the sequencer state encoding and the shared-counter width helper.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    INIT      = 2'd1,
    DELAY     = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int LOSS_COUNT_W = 8;

  // Width of one counter able to hold the largest of the three cycle limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_synchroniser.sv
// Generic multi-flop synchroniser with synchronous clear, for asynchronous
// status inputs such as the PLL lock flag.
module lock_synchroniser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic clear,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clock) begin
    if (clear) begin
      chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Qualifies PLL lock and sequences SDRAM-controller then CPU reset release.
// Optional lock-loss statistics counter: define PLL_LOCK_LOSS_COUNTER_EN.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int STABLE_CYCLES       = 1024,
  parameter int CPU_DELAY_CYCLES    = 64,
  parameter int INIT_TIMEOUT_CYCLES = 65535
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic                    sdram_init_done,
  output logic                    sdram_ctrl_reset,
  output logic                    cpu_reset,
  output logic                    init_timeout,
  output logic [LOSS_COUNT_W-1:0] lock_loss_count,
  output logic [1:0]              state_out
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, CPU_DELAY_CYCLES, INIT_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(CPU_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT_CYCLES - 1);

  logic             lock_s;
  seq_state_t       state_r;
  logic [CNT_W-1:0] count_r;
  logic             sdram_rst_r;
  logic             cpu_rst_r;
  logic             timeout_r;

  lock_synchroniser #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clock   (clock),
    .clear   (reset),
    .async_in(pll_locked),
    .sync_out(lock_s)
  );

  // Sequencer FSM: state, shared counter and registered reset outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= WAIT_LOCK;
      count_r     <= {CNT_W{1'b0}};
      sdram_rst_r <= 1'b1;
      cpu_rst_r   <= 1'b1;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          sdram_rst_r <= 1'b1;
          cpu_rst_r   <= 1'b1;
          if (!lock_s) begin
            count_r <= {CNT_W{1'b0}};
          end else if (count_r == STABLE_LAST) begin
            state_r     <= INIT;
            count_r     <= {CNT_W{1'b0}};
            sdram_rst_r <= 1'b0;
          end else begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        INIT: begin
          // Lock loss wins, but a timeout reached on the same cycle is still recorded.
          if (!lock_s) begin
            state_r     <= WAIT_LOCK;
            count_r     <= {CNT_W{1'b0}};
            sdram_rst_r <= 1'b1;
            cpu_rst_r   <= 1'b1;
            if (count_r == TIMEOUT_LAST && !sdram_init_done) begin
              timeout_r <= 1'b1;
            end else begin
              timeout_r <= timeout_r;
            end
          end else if (sdram_init_done) begin
            state_r <= DELAY;
            count_r <= {CNT_W{1'b0}};
          end else if (count_r == TIMEOUT_LAST) begin
            state_r     <= WAIT_LOCK;
            count_r     <= {CNT_W{1'b0}};
            sdram_rst_r <= 1'b1;
            cpu_rst_r   <= 1'b1;
            timeout_r   <= 1'b1;
          end else begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DELAY: begin
          if (!lock_s) begin
            state_r     <= WAIT_LOCK;
            count_r     <= {CNT_W{1'b0}};
            sdram_rst_r <= 1'b1;
            cpu_rst_r   <= 1'b1;
          end else if (!sdram_init_done) begin
            state_r <= INIT;
            count_r <= {CNT_W{1'b0}};
          end else if (count_r == DELAY_LAST) begin
            state_r   <= RUN;
            count_r   <= {CNT_W{1'b0}};
            cpu_rst_r <= 1'b0;
          end else begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_r     <= WAIT_LOCK;
            count_r     <= {CNT_W{1'b0}};
            sdram_rst_r <= 1'b1;
            cpu_rst_r   <= 1'b1;
          end else begin
            sdram_rst_r <= 1'b0;
            cpu_rst_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= WAIT_LOCK;
          count_r     <= {CNT_W{1'b0}};
          sdram_rst_r <= 1'b1;
          cpu_rst_r   <= 1'b1;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_COUNTER_EN
  logic                    lock_loss_s;
  logic [LOSS_COUNT_W-1:0] loss_count_r;

  assign lock_loss_s = (state_r != WAIT_LOCK) && !lock_s;

  // Saturating count of lock losses once the sequence has left WAIT_LOCK.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_count_r <= {LOSS_COUNT_W{1'b0}};
    end else if (lock_loss_s && (loss_count_r != {LOSS_COUNT_W{1'b1}})) begin
      loss_count_r <= loss_count_r + {{(LOSS_COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      loss_count_r <= loss_count_r;
    end
  end

  assign lock_loss_count = loss_count_r;
`else
  assign lock_loss_count = {LOSS_COUNT_W{1'b0}};
`endif

  assign sdram_ctrl_reset = sdram_rst_r;
  assign cpu_reset        = cpu_rst_r;
  assign init_timeout     = timeout_r;
  assign state_out        = state_r;

endmodule
